obi_arbiter: RTL and testbench

OBI_ARBITER -- requirements
Module: obi_arbiter

---
 rtl/obi_arbiter_pkg.sv | 17 +
 rtl/obi_id_fifo.sv | 71 +++++++
 rtl/obi_arbiter.sv | 126 ++++++++++++
 tb/tb_obi_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arbiter_pkg.sv
// Shared types for the two-master OBI arbiter.
// Master IDs, arbiter states and the default outstanding depth.
package obi_arbiter_pkg;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } master_id_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/obi_id_fifo.sv
// Response-ID FIFO: remembers which master owns each accepted request.
// Depth-limited 1-bit queue with push, pop, full, empty and count.
module obi_id_fifo
    import obi_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  master_id_e    id_i,
    input  logic          pop_i,
    output master_id_e    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    master_id_e    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= INSTR;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
            end
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Two-master (instr/data) OBI arbiter onto one shared memory port.
// Round-robin on ties, winner frozen while the memory stalls a request.
module obi_arbiter
    import obi_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [31:0]       instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    state_e        state_q, state_d;
    master_id_e    win_q, win_d;
    master_id_e    last_q, last_d;
    logic          err_q, err_d;
    master_id_e    win;
    master_id_e    head;
    logic          win_req;
    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic          unused_full;
    logic [CW-1:0] fifo_cnt;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .id_i    (win),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            win_q   <= INSTR;
            last_q  <= DATA;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Winner depends only on state and requests, never on mem_gnt_i.
    always_comb begin
        win = INSTR;
        if (state_q == ST_LOCKED) begin
            win = win_q;
        end else if (instr_req_i && data_req_i) begin
            win = (last_q == INSTR) ? DATA : INSTR;
        end else if (data_req_i) begin
            win = DATA;
        end
    end

    assign win_req = (win == INSTR) ? instr_req_i : data_req_i;
    assign accept  = mem_req_o && mem_gnt_i;
    assign pop     = mem_rvalid_i && !fifo_empty;

    always_comb begin
        state_d = ST_IDLE;
        if (mem_req_o && !mem_gnt_i) begin
            state_d = ST_LOCKED;
        end
        win_d  = win;
        last_d = accept ? win : last_q;
        err_d  = err_q || (mem_rvalid_i && fifo_empty);
    end

    always_comb begin
        mem_req_o = rst_ni && win_req && (fifo_cnt < CW'(MAX_OUTSTANDING));
        instr_gnt_o    = accept && (win == INSTR);
        data_gnt_o     = accept && (win == DATA);
        instr_rvalid_o = pop && (head == INSTR);
        data_rvalid_o  = pop && (head == DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        err_o          = err_q;
        if (win == INSTR) begin
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_wdata_o = '0;
        end else begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

endmodule

// File: tb/tb_obi_arbiter.sv
// Bench for obi_arbiter: directed vector table, reset sequence,
// then random OBI-legal traffic against a queue-based reference model.
module tb_obi_arbiter;

    localparam int MAXO = 2;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [AW-1:0] instr_addr_i;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]    data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [31:0]   data_wdata_i, data_rdata_o;
    logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_W          (AW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [3:0]  db;
        logic [31:0] da;
        bit          g;
        bit          rv;
        bit          eig, edg, eir, edr, emr, ewin, eerr;
    } vec_t;

    function automatic vec_t v(
        bit ir, logic [31:0] ia, bit dr, bit dw, logic [3:0] db,
        logic [31:0] da, bit g, bit rv,
        bit eig, bit edg, bit eir, bit edr, bit emr, bit ewin, bit eerr);
        vec_t t;
        t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.db = db; t.da = da;
        t.g = g; t.rv = rv; t.eig = eig; t.edg = edg; t.eir = eir;
        t.edr = edr; t.emr = emr; t.ewin = ewin; t.eerr = eerr;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr,
                         input bit dw, input logic [3:0] db,
                         input logic [31:0] da, input logic [31:0] dd,
                         input bit g, input bit rv, input logic [31:0] rd);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dw;
        data_be_i    = db;
        data_addr_i  = da;
        data_wdata_i = dd;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    // Handshake flags, then the mem-side mux (only while a request is up).
    task automatic expect_out(input string nm, input bit eig, input bit edg,
                              input bit eir, input bit edr, input bit emr,
                              input bit ewin, input bit eerr);
        cmp({nm, "/hs"},
            {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
             mem_req_o, err_o},
            {eig, edg, eir, edr, emr, eerr});
        if (emr) begin
            cmp({nm, "/mux"},
                {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                ewin ? {data_addr_i, data_we_i, data_be_i, data_wdata_i}
                     : {instr_addr_i, 1'b0, 4'hF, 32'h0});
        end
        cmp({nm, "/rdata"}, {instr_rdata_o, data_rdata_o},
            {mem_rdata_i, mem_rdata_i});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t        tbl[$];
    int          mq[$];
    int          mlast, mlkid, win;
    bit          mlk, merr;
    bit          ihold, dhold, wreq, emr, eg, erv, head;
    logic [31:0] ia, da, dd;
    bit          ir, dr, dw, g, rv;
    logic [3:0]  db;

    initial begin
        rst_n = 1'b0;
        drive(1, 32'h40, 1, 1, 4'h3, 32'h80, 32'h1, 1, 1, 32'h5);
        repeat (2) @(posedge clk);
        #1;
        expect_out("in_reset", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Alternating grants from reset (instr wins first tie)
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(v(1, 32'h3000, 1, 0, 4'hF, 32'h400, 1, k > 0,
                            k % 2 == 0, k % 2 == 1, k % 2 == 1,
                            k > 0 && k % 2 == 0, 1, k % 2, 0));
        end
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        // Stalled data write keeps its address while instr rises
        tbl.push_back(v(0, 0, 1, 1, 4'h3, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(1, 32'h2004, 1, 1, 4'h3, 32'h100, 0, 0,
                            0, 0, 0, 0, 1, 1, 0));
        end
        tbl.push_back(v(1, 32'h2004, 1, 1, 4'h3, 32'h100, 1, 0,
                        0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(1, 32'h2004, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        // Single instr fetch with 1-cycle response
        tbl.push_back(v(1, 32'h2000, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        // Outstanding limit, rvalid alongside third request
        tbl.push_back(v(1, 32'h2008, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 32'h2008, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 32'h2008, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 32'h2008, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        // Stray rvalid with nothing outstanding
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].db,
                  tbl[i].da, 32'hDEAD_BEEF, tbl[i].g, tbl[i].rv,
                  32'h1000_0000 + 32'(i));
            #3;
            expect_out($sformatf("vec%0d", i), tbl[i].eig, tbl[i].edg,
                       tbl[i].eir, tbl[i].edr, tbl[i].emr, tbl[i].ewin,
                       tbl[i].eerr);
            @(posedge clk);
            #1;
        end

        // Reset with two outstanding, then a late response
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h2010, 0, 0, 0, 0, 0, 1, 0, 32'h7);
            #3;
            expect_out("pre_rst", 1, 0, 0, 0, 1, 0, 0);
            @(posedge clk);
            #1;
        end
        #3;
        expect_out("full", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9);
        #3;
        expect_out("late_rv", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        expect_out("late_err", 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;

        // Random OBI-legal traffic against the reference model
        do_reset();
        mq.delete();
        mlast = 1;
        mlk   = 0;
        mlkid = 0;
        merr  = 0;
        ihold = 0;
        dhold = 0;
        ir = 0; ia = 0; dr = 0; dw = 0; db = 0; da = 0; dd = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!ihold) begin
                ir = 1'($urandom_range(0, 1));
                ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dhold) begin
                dr = 1'($urandom_range(0, 1));
                dw = 1'($urandom_range(0, 1));
                db = 4'($urandom);
                da = $urandom & 32'hFFFF_FFFC;
                dd = $urandom;
            end
            g  = $urandom_range(0, 3) != 0;
            rv = mq.size() > 0 && $urandom_range(0, 2) == 0;
            drive(ir, ia, dr, dw, db, da, dd, g, rv, $urandom);

            if (mlk) win = mlkid;
            else if (ir && dr) win = (mlast == 0) ? 1 : 0;
            else if (dr) win = 1;
            else win = 0;
            wreq = (win == 1) ? dr : ir;
            emr  = wreq && mq.size() < MAXO;
            eg   = emr && g;
            erv  = rv && mq.size() > 0;
            head = erv ? 1'(mq[0]) : 1'b0;
            #3;
            expect_out($sformatf("rand%0d", n), eg && win == 0,
                       eg && win == 1, erv && !head, erv && head,
                       emr, 1'(win), merr);
            @(posedge clk);
            if (rv && mq.size() == 0) merr = 1;
            if (erv) void'(mq.pop_front());
            if (eg) begin
                mq.push_back(win);
                mlast = win;
            end
            mlk   = emr && !g;
            mlkid = win;
            ihold = ir && !(eg && win == 0);
            dhold = dr && !(eg && win == 1);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
